bin_to_bcd_display: RTL

Sequential double-dabble converter that turns an unsigned binary count into eight packed BCD digits for the 8-digit seven-segment display driver. It sits directly upstream of the display controller, and its bcd_out drives that controller's 32-bit val_in. Nibble 0 (bcd_out[3:0]) is the rightmost digit. Each conversion takes one shift-add iteration per input bit. The result is held stable between conversions so the display never shows intermediate values.

---
 rtl/bin_to_bcd_display.sv | 106 ++++++++++
 1 files changed

// File: rtl/bin_to_bcd_display.sv
// Sequential double-dabble converter: unsigned binary to eight packed BCD digits for the display.
// Optional macro BCD_SATURATE_EN: an overflowing input shows 9999_9999 instead of value mod 10^8.
module bin_to_bcd_display #(
  parameter int          IN_WIDTH = 27,
  parameter logic [31:0] MAX_DEC  = 32'd99_999_999
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [IN_WIDTH-1:0] bin_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [31:0]         bcd_out,
  output logic                valid_out,
  output logic                ovf_out
);

  localparam int CNT_W = $clog2(IN_WIDTH + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t                state, state_next;
  logic [IN_WIDTH-1:0]   bin_sr;
  logic [31:0]           bcd_acc;
  logic [31:0]           bcd_adj;
  logic [31:0]           acc_next;
  logic [31:0]           result;
  logic [IN_WIDTH-1:0]   sr_next;
  logic [IN_WIDTH+31:0]  joint;
  logic [CNT_W-1:0]      cnt;
  logic                  ovf_pending;
  logic [31:0]           bin_ext;
  logic                  last_iter;

  assign ready_out = (state == IDLE);
  assign last_iter = (cnt == CNT_W'(1));
  assign bin_ext   = {{(32-IN_WIDTH){1'b0}}, bin_in};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (valid_in)  state_next = CONV;
      CONV: if (last_iter) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Add-3 on every nibble >= 5, nibbles independent (no carry between them).
  always_comb begin
    bcd_adj = bcd_acc;
    for (int i = 0; i < 8; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
    end
  end

  // The bit shifted out of the top of the accumulator is a ninth digit and is dropped.
  assign joint    = {bcd_adj, bin_sr} << 1;
  assign acc_next = joint[IN_WIDTH+31 -: 32];
  assign sr_next  = joint[IN_WIDTH-1:0];

`ifdef BCD_SATURATE_EN
  assign result = ovf_pending ? 32'h9999_9999 : acc_next;
`else
  assign result = acc_next;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bin_sr      <= '0;
      bcd_acc     <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      bcd_out     <= '0;
      ovf_out     <= 1'b0;
      valid_out   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            bin_sr      <= bin_in;
            bcd_acc     <= '0;
            cnt         <= CNT_W'(IN_WIDTH);
            ovf_pending <= (bin_ext > MAX_DEC);
          end
        end
        CONV: begin
          bcd_acc <= acc_next;
          bin_sr  <= sr_next;
          cnt     <= cnt - CNT_W'(1);
          if (last_iter) begin
            bcd_out   <= result;
            ovf_out   <= ovf_pending;
            valid_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
